// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter and sequencer that shares one combinational ALU.
// Only one operation is in flight at a time; each operation takes three phases: grant, execute, respond.
module alu_arbiter #(
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req0_ctrl,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req1_ctrl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry,
   input  logic             alu_overflow,
   input  logic             alu_zero,
   input  logic             alu_negative,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic [3:0]       rsp_flags
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             id_q, id_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [3:0]       alu_control_q, alu_control_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic [3:0]       rsp_flags_q, rsp_flags_d;
   logic             gnt0, gnt1;

   // Arbitration is only live in IDLE; on a tie the requester not granted last wins.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if ((state_q == IDLE) && !reset) begin
         if (req0_valid && req1_valid) begin
            if (last_grant_q == 1'b1) begin
               gnt0 = 1'b1;
            end else begin
               gnt1 = 1'b1;
            end
         end else if (req0_valid) begin
            gnt0 = 1'b1;
         end else if (req1_valid) begin
            gnt1 = 1'b1;
         end else begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
         end
      end else begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // Sequencer: grant latches operands, EXEC captures the ALU, RESP waits for the consumer.
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      id_d          = id_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_control_d = alu_control_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_id_d      = rsp_id_q;
      rsp_result_d  = rsp_result_q;
      rsp_flags_d   = rsp_flags_q;
      case (state_q)
         IDLE: begin
            if (gnt0) begin
               alu_a_d       = req0_a;
               alu_b_d       = req0_b;
               alu_control_d = req0_ctrl;
               id_d          = 1'b0;
               last_grant_d  = 1'b0;
               state_d       = EXEC;
            end else if (gnt1) begin
               alu_a_d       = req1_a;
               alu_b_d       = req1_b;
               alu_control_d = req1_ctrl;
               id_d          = 1'b1;
               last_grant_d  = 1'b1;
               state_d       = EXEC;
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            rsp_result_d = alu_result;
            rsp_flags_d  = {alu_carry, alu_overflow, alu_zero, alu_negative};
            rsp_id_d     = id_q;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; an in-flight operation is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         last_grant_q  <= 1'b1;
         id_q          <= 1'b0;
         alu_a_q       <= {WIDTH{1'b0}};
         alu_b_q       <= {WIDTH{1'b0}};
         alu_control_q <= 4'd0;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= 1'b0;
         rsp_result_q  <= {WIDTH{1'b0}};
         rsp_flags_q   <= 4'd0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         id_q          <= id_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_control_q <= alu_control_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
         rsp_result_q  <= rsp_result_d;
         rsp_flags_q   <= rsp_flags_d;
      end
   end

   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_control = alu_control_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_flags   = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stand-in ALU, a transaction-level reference model,
// directed scenarios followed by randomized traffic.
module tb_alu_arbiter;

   localparam int W = 7;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]   req0_ctrl, req1_ctrl;
   logic [W-1:0] alu_a, alu_b, alu_result;
   logic [3:0]   alu_control;
   logic         alu_carry, alu_overflow, alu_zero, alu_negative;
   logic         rsp_valid, rsp_ready, rsp_id;
   logic [W-1:0] rsp_result;
   logic [3:0]   rsp_flags;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
      .alu_zero(alu_zero), .alu_negative(alu_negative),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags)
   );

   // Stand-in ALU: {carry, overflow, zero, negative, result}
   function automatic logic [W+3:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] c);
      logic [W-1:0] s, r;
      logic [W:0]   sum;
      logic         cy, ov;
      case (c[3:2])
         2'd0:    s = a;
         2'd1:    s = {a[W-2:0], 1'b0};
         2'd2:    s = {1'b0, a[W-1:1]};
         default: s = {a[W-2:0], a[W-1]};
      endcase
      sum = '0;
      case (c[1:0])
         2'd0: begin
            sum = {1'b0, s} + {1'b0, b};
            r = sum[W-1:0]; cy = sum[W];
            ov = (s[W-1] == b[W-1]) && (r[W-1] != s[W-1]);
         end
         2'd1: begin
            sum = {1'b0, s} + {1'b0, ~b} + 8'd1;
            r = sum[W-1:0]; cy = sum[W];
            ov = (s[W-1] != b[W-1]) && (r[W-1] != s[W-1]);
         end
         2'd2:    begin r = s & b; cy = 1'b0; ov = 1'b0; end
         default: begin r = s | b; cy = 1'b0; ov = 1'b0; end
      endcase
      return {cy, ov, (r == '0), r[W-1], r};
   endfunction

   logic [W+3:0] alu_out;
   assign alu_out = alu_fn(alu_a, alu_b, alu_control);
   assign {alu_carry, alu_overflow, alu_zero, alu_negative, alu_result} = alu_out;

   // Reference model: one transaction at a time, tracked by its age since grant.
   logic         m_busy;
   int           m_age;
   logic         m_last;
   logic         m_op_id;
   logic [W-1:0] m_op_a, m_op_b;
   logic [3:0]   m_op_c;
   logic         m_rsp_id;
   logic [W-1:0] m_rsp_result;
   logic [3:0]   m_rsp_flags;

   task automatic model_reset();
      m_busy = 1'b0; m_age = 0; m_last = 1'b1; m_op_id = 1'b0;
      m_op_a = '0; m_op_b = '0; m_op_c = 4'd0;
      m_rsp_id = 1'b0; m_rsp_result = '0; m_rsp_flags = 4'd0;
   endtask

   function automatic int exp_winner();
      if (reset || m_busy) return -1;
      if (req0_valid && req1_valid) return (m_last == 1'b1) ? 0 : 1;
      if (req0_valid) return 0;
      if (req1_valid) return 1;
      return -1;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Check one cycle against the model, then advance the model over the edge.
   task automatic cycle();
      int win;
      logic [W+3:0] r;
      #1;
      win = exp_winner();
      check_eq("req0_ready", {31'd0, req0_ready}, {31'd0, win == 0});
      check_eq("req1_ready", {31'd0, req1_ready}, {31'd0, win == 1});
      check_eq("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_busy && (m_age == 2)});
      check_eq("rsp_id", {31'd0, rsp_id}, {31'd0, m_rsp_id});
      check_eq("rsp_result", {25'd0, rsp_result}, {25'd0, m_rsp_result});
      check_eq("rsp_flags", {28'd0, rsp_flags}, {28'd0, m_rsp_flags});
      check_eq("alu_a", {25'd0, alu_a}, {25'd0, m_op_a});
      check_eq("alu_b", {25'd0, alu_b}, {25'd0, m_op_b});
      check_eq("alu_control", {28'd0, alu_control}, {28'd0, m_op_c});
      if (reset) begin
         model_reset();
      end else if (!m_busy) begin
         if (win >= 0) begin
            m_busy = 1'b1; m_age = 1; m_last = (win == 1); m_op_id = (win == 1);
            m_op_a = (win == 1) ? req1_a : req0_a;
            m_op_b = (win == 1) ? req1_b : req0_b;
            m_op_c = (win == 1) ? req1_ctrl : req0_ctrl;
         end
      end else if (m_age == 1) begin
         r = alu_fn(m_op_a, m_op_b, m_op_c);
         m_age = 2; m_rsp_id = m_op_id; m_rsp_result = r[W-1:0]; m_rsp_flags = r[W+3:W];
      end else if (rsp_ready) begin
         m_busy = 1'b0; m_age = 0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   int           n_rsp;
   logic [W-1:0] tie_res [4];
   logic         tie_id  [4];

   initial begin
      reset = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req0_ctrl = 4'd0;
      req1_a = '0; req1_b = '0; req1_ctrl = 4'd0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      model_reset();
      do_reset();

      // Single op: 5 + 3
      req0_valid = 1'b1; req0_a = 7'd5; req0_b = 7'd3; req0_ctrl = 4'b0000;
      cycle();
      req0_valid = 1'b0;
      cycle();
      check_eq("single_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("single_result", {25'd0, rsp_result}, 32'd8);
      check_eq("single_flags", {28'd0, rsp_flags}, 32'd0);
      check_eq("single_id", {31'd0, rsp_id}, 32'd0);
      cycle();

      // Tie after reset: alternate 0,1,0,1
      do_reset();
      req0_valid = 1'b1; req0_a = 7'd1; req0_b = 7'd1;
      req1_valid = 1'b1; req1_a = 7'd2; req1_b = 7'd2; req1_ctrl = 4'b0000;
      n_rsp = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (rsp_valid && n_rsp < 4) begin
            tie_res[n_rsp] = rsp_result; tie_id[n_rsp] = rsp_id; n_rsp++;
         end
      end
      check_eq("tie_count", n_rsp, 32'd4);
      for (int i = 0; i < 4; i++) begin
         check_eq("tie_result", {25'd0, tie_res[i]}, (i % 2 == 0) ? 32'd2 : 32'd4);
         check_eq("tie_id", {31'd0, tie_id[i]}, (i % 2 == 0) ? 32'd0 : 32'd1);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      cycle();

      // Back-pressure
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 7'd20; req0_b = 7'd6; req0_ctrl = 4'b0001;
      cycle();
      req0_valid = 1'b0;
      cycle();
      req0_valid = 1'b1; req1_valid = 1'b1; req0_a = 7'd9; req1_a = 7'd11;
      for (int i = 0; i < 5; i++) cycle();
      check_eq("bp_result", {25'd0, rsp_result}, 32'd14);
      rsp_ready = 1'b1;
      cycle();
      check_eq("bp_drop", {31'd0, rsp_valid}, 32'd0);
      cycle();
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int i = 0; i < 3; i++) cycle();

      // Flags
      req1_valid = 1'b1; req1_a = 7'h7F; req1_b = 7'h01; req1_ctrl = 4'b0000;
      cycle();
      req1_valid = 1'b0;
      cycle();
      check_eq("flag_result0", {25'd0, rsp_result}, 32'd0);
      check_eq("flag_cz", {28'd0, rsp_flags}, 32'hA);
      check_eq("flag_id", {31'd0, rsp_id}, 32'd1);
      cycle();
      req1_valid = 1'b1; req1_a = 7'h3F; req1_b = 7'h01;
      cycle();
      req1_valid = 1'b0;
      cycle();
      check_eq("flag_result40", {25'd0, rsp_result}, 32'h40);
      check_eq("flag_vn", {28'd0, rsp_flags}, 32'h5);
      cycle();

      // Reset during EXEC
      req0_valid = 1'b1; req0_a = 7'd33; req0_b = 7'd44; req0_ctrl = 4'b0110;
      cycle();
      req0_valid = 1'b0; reset = 1'b1;
      cycle();
      reset = 1'b0;
      check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("rst_alu_a", {25'd0, alu_a}, 32'd0);
      check_eq("rst_alu_control", {28'd0, alu_control}, 32'd0);
      for (int i = 0; i < 3; i++) cycle();
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1 check_eq("rst_tie_req0", {31'd0, req0_ready}, 32'd1);
      cycle();
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int i = 0; i < 3; i++) cycle();

      // Idle stability
      for (int i = 0; i < 10; i++) cycle();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         reset      = ($urandom_range(0, 63) == 0);
         req0_valid = $urandom_range(0, 1);
         req1_valid = $urandom_range(0, 1);
         req0_a = W'($urandom); req0_b = W'($urandom); req0_ctrl = 4'($urandom);
         req1_a = W'($urandom); req1_b = W'($urandom); req1_ctrl = 4'($urandom);
         rsp_ready  = ($urandom_range(0, 3) != 0);
         cycle();
      end
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
